alisim_site_sampler: RTL

Parametrised successor to the fixed 8-position `Controller`. It evolves one alignment along one tree branch, one site per cycle. For each site it takes the parent nucleotide and draws a child nucleotide from the matching row of a 4x4 substitution matrix P, using an internal 16-bit LFSR as the random source. It sits between the branch scheduler, which supplies `matrix_P` and `parent_alig`, and the alignment store, which consumes `nucl_out` beats or the final `child_alig` word.

---
 rtl/alisim_site_sampler_pkg.sv | 29 ++
 rtl/alisim_site_sampler_if.sv | 17 +
 rtl/alisim_site_sampler_lfsr16.sv | 35 +++
 rtl/alisim_site_sampler.sv | 138 +++++++++++++
 4 files changed

// File: rtl/alisim_site_sampler_pkg.sv
// alisim_pkg: shared constants and helpers for the site sampler.
//   Nucleotide encoding (A=0, C=1, G=2, T=3), LFSR polynomial mask,
//   zero-seed substitute, FSM state type and the P-matrix bit-offset helper.
package alisim_pkg;

  localparam logic [1:0] NUC_A = 2'd0;
  localparam logic [1:0] NUC_C = 2'd1;
  localparam logic [1:0] NUC_G = 2'd2;
  localparam logic [1:0] NUC_T = 2'd3;

  localparam int unsigned NUM_NUC = 4;

  localparam logic [15:0] LFSR_MASK     = 16'hB400;
  localparam logic [15:0] LFSR_ZERO_SUB = 16'hACE1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_DRAIN,
    ST_DONE
  } state_t;

  // Bit offset of P[i][j] in the row-major flattened matrix.
  function automatic int unsigned p_idx(input logic [1:0] i, input logic [1:0] j,
                                        input int unsigned prob_w = 10);
    return (NUM_NUC * 32'(i) + 32'(j)) * prob_w;
  endfunction

endpackage

// File: rtl/alisim_site_sampler_if.sv
// alisim_site_sampler_if: child-nucleotide beat stream.
//   nucl_valid - beat present (source -> sink)
//   nucl_ready - sink accepts beat (sink -> source)
//   nucl_out   - child nucleotide of the beat
//   pos        - site index of the beat
// master = sampler side, slave = alignment-store side.
interface alisim_site_sampler_if #(
  parameter int unsigned POS_W = 3
) ();
  logic             nucl_valid;
  logic             nucl_ready;
  logic [1:0]       nucl_out;
  logic [POS_W-1:0] pos;

  modport master (output nucl_valid, output nucl_out, output pos, input nucl_ready);
  modport slave  (input nucl_valid, input nucl_out, input pos, output nucl_ready);
endinterface

// File: rtl/alisim_site_sampler_lfsr16.sv
// alisim_lfsr16: 16-bit right-shifting Galois LFSR, x^16+x^14+x^13+x^11+1.
//   clk      - clock, rising edge
//   reset    - synchronous active-low; state <- SEED
//   load     - load load_val (zero is replaced by LFSR_ZERO_SUB); wins over step
//   load_val - value to load
//   step     - advance one position
//   state    - current LFSR value
module alisim_lfsr16
  import alisim_pkg::*;
#(
  parameter logic [15:0] SEED = 16'hACE1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic [15:0] load_val,
  input  logic        step,
  output logic [15:0] state
);

  logic [15:0] r_state;

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= SEED;
    end else if (load) begin
      r_state <= (load_val == '0) ? LFSR_ZERO_SUB : load_val;
    end else if (step) begin
      r_state <= (r_state >> 1) ^ (r_state[0] ? LFSR_MASK : '0);
    end
  end

  assign state = r_state;

endmodule

// File: rtl/alisim_site_sampler.sv
// alisim_site_sampler: evolves one alignment along one branch, one site per
// cycle, drawing each child nucleotide from the parent's row of P using an
// internal LFSR.
//   clk, reset    - clock / synchronous active-low reset
//   start         - begin a run (IDLE only)
//   seed_load     - load seed into the LFSR (IDLE only)
//   seed          - new LFSR seed
//   parent_alig   - parent nucleotides, site k at [2k+1:2k]
//   matrix_P      - 4x4 substitution matrix, P[i][j] at p_idx(i,j)
//   busy          - run in progress (RUN/DRAIN/DONE)
//   done          - one-cycle completion pulse
//   child_alig    - child alignment, same layout as parent_alig
//   nucl          - beat stream (valid/ready, nucl_out, pos)
module alisim_site_sampler
  import alisim_pkg::*;
#(
  parameter int unsigned NUM_SITES = 8,
  parameter int unsigned PROB_W    = 10,
  parameter logic [15:0] LFSR_SEED = 16'hACE1,
  parameter int unsigned POS_W     = $clog2(NUM_SITES)
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic                     seed_load,
  input  logic [15:0]              seed,
  input  logic [2*NUM_SITES-1:0]   parent_alig,
  input  logic [16*PROB_W-1:0]     matrix_P,
  output logic                     busy,
  output logic                     done,
  output logic [2*NUM_SITES-1:0]   child_alig,
  alisim_site_sampler_if.master    nucl
);

  localparam logic [PROB_W+1:0] SAT    = (PROB_W+2)'((1 << PROB_W) - 1);
  localparam logic [15:0]       R_MASK = 16'((1 << PROB_W) - 1);

  state_t                   r_state;
  logic                     r_busy;
  logic                     r_done;
  logic                     r_valid;
  logic [1:0]               r_nucl;
  logic [POS_W-1:0]         r_pos;
  logic [POS_W-1:0]         r_k;
  logic [2*NUM_SITES-1:0]   r_par;
  logic [2*NUM_SITES-1:0]   r_child;
  logic [16*PROB_W-1:0]     r_P;

  logic [15:0]              w_lfsr;
  logic                     w_load;
  logic                     w_issue;
  logic [1:0]               w_row;
  logic [PROB_W+1:0]        w_c0, w_c1, w_c2, w_r;
  logic [1:0]               w_child;

  alisim_lfsr16 #(.SEED(LFSR_SEED)) u_lfsr (
    .clk      (clk),
    .reset    (reset),
    .load     (w_load),
    .load_val (seed),
    .step     (w_issue),
    .state    (w_lfsr)
  );

  always_comb begin
    w_load  = (r_state == ST_IDLE) && seed_load;
    w_issue = (r_state == ST_RUN) && (!r_valid || nucl.nucl_ready);
    w_row   = r_par[{r_k, 1'b0} +: 2];
    w_c0    = {2'b00, r_P[p_idx(w_row, 2'd0, PROB_W) +: PROB_W]};
    w_c1    = w_c0 + {2'b00, r_P[p_idx(w_row, 2'd1, PROB_W) +: PROB_W]};
    w_c2    = w_c1 + {2'b00, r_P[p_idx(w_row, 2'd2, PROB_W) +: PROB_W]};
    w_r     = (PROB_W+2)'(w_lfsr & R_MASK);
    // A saturated cumulative sum claims every remaining draw value.
    if (w_r < w_c0 || w_c0 >= SAT)      w_child = NUC_A;
    else if (w_r < w_c1 || w_c1 >= SAT) w_child = NUC_C;
    else if (w_r < w_c2 || w_c2 >= SAT) w_child = NUC_G;
    else                                w_child = NUC_T;
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      r_state <= ST_IDLE;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
      r_valid <= 1'b0;
      r_nucl  <= '0;
      r_pos   <= '0;
      r_k     <= '0;
      r_par   <= '0;
      r_child <= '0;
      r_P     <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_par   <= parent_alig;
            r_P     <= matrix_P;
            r_k     <= '0;
            r_child <= '0;
            r_busy  <= 1'b1;
            r_state <= ST_RUN;
          end
        end
        ST_RUN: begin
          if (w_issue) begin
            r_nucl                    <= w_child;
            r_pos                     <= r_k;
            r_valid                   <= 1'b1;
            r_child[{r_k, 1'b0} +: 2] <= w_child;
            if (r_k == POS_W'(NUM_SITES - 1)) r_state <= ST_DRAIN;
            else                              r_k     <= r_k + POS_W'(1);
          end
        end
        ST_DRAIN: begin
          if (r_valid && nucl.nucl_ready) begin
            r_valid <= 1'b0;
            r_done  <= 1'b1;
            r_state <= ST_DONE;
          end
        end
        ST_DONE: begin
          r_done  <= 1'b0;
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

  assign busy            = r_busy;
  assign done            = r_done;
  assign child_alig      = r_child;
  assign nucl.nucl_valid = r_valid;
  assign nucl.nucl_out   = r_nucl;
  assign nucl.pos        = r_pos;

endmodule
